// File: rtl/bitstream_loader_pkg.sv
// Shared types and constants for the bitstream loader.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package bitstream_loader_pkg;

    localparam int WORD_W = 32;

    localparam int DEF_SETUP_CYCLES    = 2;
    localparam int DEF_GAP_CYCLES      = 2;
    localparam int DEF_SETTLE_CYCLES   = 100;
    localparam int DEF_USER_RST_CYCLES = 5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_SETUP,
        ST_STROBE,
        ST_GAP,
        ST_SETTLE,
        ST_URST,
        ST_DONE
    } state_e;

    // Largest of the four cycle counts; sizes the shared delay counter.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/bitstream_loader_if.sv
// Handshake and data bundle between the loader, its ROM and the fabric config port.
// Latency: n/a (wires only).
// Backpressure: none; the fabric accepts one strobed word per strobe, ROM answers in one cycle.
interface bitstream_loader_if
    import bitstream_loader_pkg::*;
#(
    parameter int AW = 13
);
    logic              start;
    logic [AW:0]       num_words;
    logic              mem_rd;
    logic [AW-1:0]     mem_addr;
    logic [WORD_W-1:0] mem_rdata;
    logic [WORD_W-1:0] SelfWriteData;
    logic              SelfWriteStrobe;
    logic              user_rst;
    logic              busy;
    logic              done;

    // Loader side.
    modport master (
        input  start, num_words, mem_rdata,
        output mem_rd, mem_addr, SelfWriteData, SelfWriteStrobe, user_rst, busy, done
    );

    // Environment side: controller, ROM and fabric.
    modport slave (
        output start, num_words, mem_rdata,
        input  mem_rd, mem_addr, SelfWriteData, SelfWriteStrobe, user_rst, busy, done
    );
endinterface

// File: rtl/bitstream_loader_delay_cnt.sv
// Loadable down-counter with zero flag, shared by all timed loader states.
// Latency: load value visible the cycle after load_i; counts down one per cycle, sticks at 0.
// Backpressure: none.
module loader_delay_cnt #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load takes priority, otherwise decrement until zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/bitstream_loader.sv
// Streams ROM words into the fabric self-config port, then pulses the user-design reset.
// Latency: mem_rd one cycle after start; 1+1+SETUP+1+GAP cycles per word, then SETTLE + USER_RST + 1 to done.
// Backpressure: none; start is ignored while busy (not queued).
module bitstream_loader
    import bitstream_loader_pkg::*;
#(
    parameter int MAX_WORDS       = 8192,
    parameter int AW              = $clog2(MAX_WORDS),
    parameter int SETUP_CYCLES    = DEF_SETUP_CYCLES,
    parameter int GAP_CYCLES      = DEF_GAP_CYCLES,
    parameter int SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
    parameter int USER_RST_CYCLES = DEF_USER_RST_CYCLES
) (
    input  logic               CLK,
    input  logic               resetn,
    bitstream_loader_if.master bus
);
    localparam int DLY_MAX = max4(SETUP_CYCLES, GAP_CYCLES, SETTLE_CYCLES, USER_RST_CYCLES);
    localparam int DW      = $clog2(DLY_MAX) + 1;

    // Counter reload values are N-1 so that the state lasts exactly N cycles.
    localparam logic [DW-1:0] SETUP_LD  = DW'(SETUP_CYCLES - 1);
    localparam logic [DW-1:0] GAP_LD    = DW'(GAP_CYCLES - 1);
    localparam logic [DW-1:0] SETTLE_LD = DW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] URST_LD   = DW'(USER_RST_CYCLES - 1);
    localparam logic [AW:0]   MAX_CNT   = (AW+1)'(MAX_WORDS);

    state_e            state_q;
    logic [AW:0]       word_cnt_q;
    logic [AW-1:0]     mem_addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic              mem_rd_q;
    logic              strobe_q;
    logic              user_rst_q;
    logic              busy_q;
    logic              done_q;

    logic [AW:0]       num_clamped_d;
    logic              accept_d;
    logic              last_word_d;
    logic              dly_load_d;
    logic [DW-1:0]     dly_val_d;
    logic              dly_zero;

    // Start qualification, word-count clamp and last-word detect.
    always_comb begin
        num_clamped_d = (bus.num_words > MAX_CNT) ? MAX_CNT : bus.num_words;
        accept_d      = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        last_word_d   = (word_cnt_q == (AW+1)'(1));
    end

    // Reload the shared delay counter on every transition into a timed state.
    always_comb begin
        dly_load_d = 1'b0;
        dly_val_d  = '0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_d && (num_clamped_d == '0)) begin
                    dly_load_d = 1'b1;
                    dly_val_d  = SETTLE_LD;
                end
            end
            ST_WAIT: begin
                dly_load_d = 1'b1;
                dly_val_d  = SETUP_LD;
            end
            ST_STROBE: begin
                dly_load_d = 1'b1;
                dly_val_d  = GAP_LD;
            end
            ST_GAP: begin
                if (dly_zero && last_word_d) begin
                    dly_load_d = 1'b1;
                    dly_val_d  = SETTLE_LD;
                end
            end
            ST_SETTLE: begin
                if (dly_zero) begin
                    dly_load_d = 1'b1;
                    dly_val_d  = URST_LD;
                end
            end
            default: begin
                dly_load_d = 1'b0;
            end
        endcase
    end

    loader_delay_cnt #(
        .W (DW)
    ) u_delay (
        .clk_i      (CLK),
        .rst_ni     (resetn),
        .load_i     (dly_load_d),
        .load_val_i (dly_val_d),
        .zero_o     (dly_zero)
    );

    // Load sequencer; every output is set on the edge that enters its state.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            word_cnt_q <= '0;
            mem_addr_q <= '0;
            wdata_q    <= '0;
            mem_rd_q   <= 1'b0;
            strobe_q   <= 1'b0;
            user_rst_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept_d) begin
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        mem_addr_q <= '0;
                        word_cnt_q <= num_clamped_d;
                        if (num_clamped_d == '0) begin
                            state_q <= ST_SETTLE;
                        end else begin
                            state_q  <= ST_FETCH;
                            mem_rd_q <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    mem_rd_q <= 1'b0;
                    state_q  <= ST_WAIT;
                end
                ST_WAIT: begin
                    wdata_q <= bus.mem_rdata;
                    state_q <= ST_SETUP;
                end
                ST_SETUP: begin
                    if (dly_zero) begin
                        strobe_q <= 1'b1;
                        state_q  <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    strobe_q <= 1'b0;
                    state_q  <= ST_GAP;
                end
                ST_GAP: begin
                    if (dly_zero) begin
                        word_cnt_q <= word_cnt_q - (AW+1)'(1);
                        mem_addr_q <= mem_addr_q + AW'(1);
                        if (last_word_d) begin
                            state_q <= ST_SETTLE;
                        end else begin
                            mem_rd_q <= 1'b1;
                            state_q  <= ST_FETCH;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (dly_zero) begin
                        user_rst_q <= 1'b1;
                        state_q    <= ST_URST;
                    end
                end
                ST_URST: begin
                    if (dly_zero) begin
                        user_rst_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= ST_DONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_rd          = mem_rd_q;
    assign bus.mem_addr        = mem_addr_q;
    assign bus.SelfWriteData   = wdata_q;
    assign bus.SelfWriteStrobe = strobe_q;
    assign bus.user_rst        = user_rst_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
endmodule

// File: tb/tb_bitstream_loader.sv
// Directed bench for bitstream_loader: timing, data, clamp, ignored start and mid-load reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_bitstream_loader;
    localparam int MAXW = 8192;
    localparam int AW   = 13;

    logic CLK    = 1'b0;
    logic resetn = 1'b0;
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_err  = 0;

    bitstream_loader_if #(.AW(AW)) bus ();

    bitstream_loader #(
        .MAX_WORDS       (MAXW),
        .AW              (AW),
        .SETUP_CYCLES    (2),
        .GAP_CYCLES      (2),
        .SETTLE_CYCLES   (100),
        .USER_RST_CYCLES (5)
    ) dut (
        .CLK    (CLK),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
        case (a)
            13'd0:   return 32'h11223344;
            13'd1:   return 32'hA5A5A5A5;
            13'd2:   return 32'hDEADBEEF;
            default: return {16'hB000, 3'b000, a};
        endcase
    endfunction

    // Synchronous ROM: data one cycle after mem_rd.
    always @(posedge CLK) begin
        if (bus.mem_rd === 1'b1) bus.mem_rdata <= rom_word(bus.mem_addr);
    end

    // Monitor: records reads, strobes, data stability and pulse edges.
    logic [AW-1:0] rd_addr[$];
    int            rd_cyc[$];
    logic [31:0]   strb_data[$];
    int            strb_cyc[$];
    int            strb_stable[$];
    logic [31:0]   gap_data[$];
    logic [31:0]   prev_data     = '0;
    int            stable        = 0;
    int            since_strb    = 100;
    logic          prev_urst     = 1'b0;
    logic          prev_done     = 1'b0;
    int            urst_rise_cyc = -1;
    int            urst_w        = 0;
    int            done_rise_cyc = -1;

    always @(negedge CLK) begin
        if (bus.mem_rd === 1'b1) begin
            rd_addr.push_back(bus.mem_addr);
            rd_cyc.push_back(cyc);
        end
        if (bus.SelfWriteData !== prev_data) stable = 1;
        else stable++;
        prev_data = bus.SelfWriteData;
        if (bus.SelfWriteStrobe === 1'b1) begin
            strb_data.push_back(bus.SelfWriteData);
            strb_cyc.push_back(cyc);
            strb_stable.push_back(stable);
            since_strb = 0;
        end else if (since_strb < 100) begin
            since_strb++;
        end
        if (since_strb == 2) gap_data.push_back(bus.SelfWriteData);
        if (bus.user_rst === 1'b1 && prev_urst !== 1'b1) urst_rise_cyc = cyc;
        if (bus.user_rst !== 1'b1 && prev_urst === 1'b1) urst_w = cyc - urst_rise_cyc;
        prev_urst = bus.user_rst;
        if (bus.done === 1'b1 && prev_done !== 1'b1) done_rise_cyc = cyc;
        prev_done = bus.done;
    end

    task automatic do_start(input int n, output int t0);
        @(negedge CLK);
        bus.num_words = n[AW:0];
        bus.start     = 1'b1;
        @(negedge CLK);
        bus.start     = 1'b0;
        t0            = cyc;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && bus.done !== 1'b1; i++) @(negedge CLK);
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_reset;
        bus.start     = 1'b0;
        bus.num_words = '0;
        resetn        = 1'b0;
        repeat (3) @(negedge CLK);
        n_cmp++;
        if ({bus.mem_rd, bus.mem_addr, bus.SelfWriteData, bus.SelfWriteStrobe,
             bus.user_rst, bus.busy, bus.done} !== 50'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %0h expected 0",
                     {bus.mem_rd, bus.mem_addr, bus.SelfWriteData, bus.SelfWriteStrobe,
                      bus.user_rst, bus.busy, bus.done});
        end
        resetn = 1'b1;
    endtask

    task automatic test_three_words;
        int t0, sb, rb, gb;
        logic [31:0] exp_w[3];
        exp_w[0] = 32'h11223344;
        exp_w[1] = 32'hA5A5A5A5;
        exp_w[2] = 32'hDEADBEEF;
        sb = strb_data.size();
        rb = rd_addr.size();
        gb = gap_data.size();
        do_start(3, t0);
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.mem_rd !== 1'b1 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL three_start_flags: busy/mem_rd/done got %b%b%b expected 110",
                     bus.busy, bus.mem_rd, bus.done);
        end
        wait_done(300);
        n_cmp++;
        if (bus.done !== 1'b1) begin
            n_err++;
            $display("FAIL three_done: got %b expected 1", bus.done);
        end
        n_cmp++;
        if (strb_data.size() - sb !== 3 || rd_addr.size() - rb !== 3) begin
            n_err++;
            $display("FAIL three_counts: strobes %0d reads %0d expected 3 3",
                     strb_data.size() - sb, rd_addr.size() - rb);
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (strb_data[sb+k] !== exp_w[k] || gap_data[gb+k] !== exp_w[k]) begin
                    n_err++;
                    $display("FAIL three_data%0d: strobe %h gap %h expected %h",
                             k, strb_data[sb+k], gap_data[gb+k], exp_w[k]);
                end
                n_cmp++;
                if (strb_cyc[sb+k] !== t0 + 4 + 7*k || strb_stable[sb+k] < 3) begin
                    n_err++;
                    $display("FAIL three_strobe_time%0d: cyc %0d stable %0d expected cyc %0d stable>=3",
                             k, strb_cyc[sb+k] - t0, strb_stable[sb+k], 4 + 7*k);
                end
                n_cmp++;
                if (rd_addr[rb+k] !== AW'(k) || rd_cyc[rb+k] !== t0 + 7*k) begin
                    n_err++;
                    $display("FAIL three_read%0d: addr %0d at %0d expected addr %0d at %0d",
                             k, rd_addr[rb+k], rd_cyc[rb+k] - t0, k, 7*k);
                end
            end
        end
        n_cmp++;
        if (urst_rise_cyc !== t0 + 121 || urst_w !== 5) begin
            n_err++;
            $display("FAIL three_user_rst: rise %0d width %0d expected rise 121 width 5",
                     urst_rise_cyc - t0, urst_w);
        end
        n_cmp++;
        if (done_rise_cyc !== t0 + 126 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL three_done_time: rise %0d busy %b expected rise 126 busy 0",
                     done_rise_cyc - t0, bus.busy);
        end
        n_cmp++;
        if (bus.SelfWriteData !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL three_data_hold: got %h expected deadbeef", bus.SelfWriteData);
        end
    endtask

    task automatic test_zero_words;
        int t0, sb, rb;
        sb = strb_data.size();
        rb = rd_addr.size();
        do_start(0, t0);
        wait_done(300);
        n_cmp++;
        if (strb_data.size() != sb || rd_addr.size() != rb) begin
            n_err++;
            $display("FAIL zero_activity: strobes %0d reads %0d expected 0 0",
                     strb_data.size() - sb, rd_addr.size() - rb);
        end
        n_cmp++;
        if (urst_rise_cyc !== t0 + 100 || urst_w !== 5) begin
            n_err++;
            $display("FAIL zero_user_rst: rise %0d width %0d expected rise 100 width 5",
                     urst_rise_cyc - t0, urst_w);
        end
        n_cmp++;
        if (bus.done !== 1'b1 || done_rise_cyc !== t0 + 105) begin
            n_err++;
            $display("FAIL zero_done: done %b rise %0d expected 1 at 105",
                     bus.done, done_rise_cyc - t0);
        end
        n_cmp++;
        if (bus.SelfWriteData !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL zero_data_hold: got %h expected deadbeef", bus.SelfWriteData);
        end
    endtask

    task automatic test_start_while_busy;
        int t0, sb, rb;
        sb = strb_data.size();
        rb = rd_addr.size();
        do_start(3, t0);
        repeat (9) @(negedge CLK);
        bus.num_words = (AW+1)'(1);
        bus.start     = 1'b1;
        @(negedge CLK);
        bus.start     = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL busy_flags: busy %b done %b expected 1 0", bus.busy, bus.done);
        end
        wait_done(300);
        n_cmp++;
        if (strb_data.size() - sb !== 3 || done_rise_cyc !== t0 + 126) begin
            n_err++;
            $display("FAIL busy_ignored: strobes %0d done at %0d expected 3 at 126",
                     strb_data.size() - sb, done_rise_cyc - t0);
        end
        n_cmp++;
        if (rd_addr.size() - rb !== 3 || rd_addr[rd_addr.size()-1] !== AW'(2)) begin
            n_err++;
            $display("FAIL busy_reads: reads %0d last %0d expected 3 last 2",
                     rd_addr.size() - rb, rd_addr[rd_addr.size()-1]);
        end
    endtask

    task automatic test_reset_mid_strobe;
        int t0, t1, sb, rb;
        bit seen;
        do_start(3, t0);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge CLK);
            if (bus.SelfWriteStrobe === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL rst_strobe_seen: got 0 expected 1");
        end
        resetn = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if ({bus.mem_rd, bus.mem_addr, bus.SelfWriteData, bus.SelfWriteStrobe,
             bus.user_rst, bus.busy, bus.done} !== 50'd0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: got %0h expected 0",
                     {bus.mem_rd, bus.mem_addr, bus.SelfWriteData, bus.SelfWriteStrobe,
                      bus.user_rst, bus.busy, bus.done});
        end
        resetn = 1'b1;
        @(negedge CLK);
        sb = strb_data.size();
        rb = rd_addr.size();
        do_start(2, t1);
        n_cmp++;
        if (bus.mem_rd !== 1'b1 || bus.mem_addr !== '0) begin
            n_err++;
            $display("FAIL rst_restart_addr: mem_rd %b addr %0d expected 1 0",
                     bus.mem_rd, bus.mem_addr);
        end
        wait_done(300);
        n_cmp++;
        if (strb_data.size() - sb !== 2 || rd_addr.size() - rb !== 2 ||
            done_rise_cyc !== t1 + 119) begin
            n_err++;
            $display("FAIL rst_restart_load: strobes %0d reads %0d done at %0d expected 2 2 119",
                     strb_data.size() - sb, rd_addr.size() - rb, done_rise_cyc - t1);
        end else begin
            n_cmp++;
            if (strb_data[sb] !== 32'h11223344 || strb_data[sb+1] !== 32'hA5A5A5A5) begin
                n_err++;
                $display("FAIL rst_restart_data: got %h %h expected 11223344 a5a5a5a5",
                         strb_data[sb], strb_data[sb+1]);
            end
        end
    endtask

    task automatic test_clamp;
        int t0, sb, rb, bad;
        sb = strb_data.size();
        rb = rd_addr.size();
        do_start(9000, t0);
        wait_done(60000);
        n_cmp++;
        if (bus.done !== 1'b1 || done_rise_cyc !== t0 + 7*MAXW + 105) begin
            n_err++;
            $display("FAIL clamp_done: done %b at %0d expected 1 at %0d",
                     bus.done, done_rise_cyc - t0, 7*MAXW + 105);
        end
        n_cmp++;
        if (strb_data.size() - sb !== MAXW || rd_addr.size() - rb !== MAXW) begin
            n_err++;
            $display("FAIL clamp_counts: strobes %0d reads %0d expected %0d",
                     strb_data.size() - sb, rd_addr.size() - rb, MAXW);
        end else begin
            bad = 0;
            for (int k = 0; k < MAXW; k++) begin
                if (rd_addr[rb+k] !== AW'(k)) bad++;
            end
            n_cmp++;
            if (bad !== 0 || rd_addr[rb+MAXW-1] !== AW'(MAXW-1)) begin
                n_err++;
                $display("FAIL clamp_addrs: out-of-order %0d last %0d expected 0 last %0d",
                         bad, rd_addr[rb+MAXW-1], MAXW-1);
            end
            n_cmp++;
            if (strb_data[sb+MAXW-1] !== rom_word(AW'(MAXW-1))) begin
                n_err++;
                $display("FAIL clamp_last_data: got %h expected %h",
                         strb_data[sb+MAXW-1], rom_word(AW'(MAXW-1)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_three_words();
        test_zero_words();
        test_start_while_busy();
        test_reset_mid_strobe();
        test_clamp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
